// File: rtl/audio_pkg.sv
// Shared definitions for the audio output clients: player state encoding and controller sample width.
package audio_pkg;
  localparam int AUDIO_SAMPLE_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t LOAD  = 2'd2;
  localparam state_t PUSH  = 2'd3;
endpackage

// File: rtl/audio_clip_player_if.sv
// Write port of the Audio_Controller output FIFO as seen by a sample producer.
interface audio_clip_player_if #(
  parameter int SAMPLE_W = audio_pkg::AUDIO_SAMPLE_W
);
  logic                       audio_out_allowed;
  logic                       write_audio_out;
  logic signed [SAMPLE_W-1:0] left_channel_audio_out;
  logic signed [SAMPLE_W-1:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/audio_volume_scale.sv
// Places a signed PCM word in the top bits of a wider sample and attenuates it by an arithmetic shift.
module audio_volume_scale #(
  parameter int ROM_W    = 16,
  parameter int SAMPLE_W = 32
) (
  input  logic signed [ROM_W-1:0]    sample,
  input  logic        [2:0]          shift,
  output logic signed [SAMPLE_W-1:0] scaled
);

  function automatic logic signed [SAMPLE_W-1:0] scale_sample(
    input logic signed [ROM_W-1:0] s,
    input logic        [2:0]       sh
  );
    logic signed [SAMPLE_W-1:0] padded;
    padded = {s, {(SAMPLE_W-ROM_W){1'b0}}};
    return padded >>> sh;
  endfunction

  assign scaled = scale_sample(sample, shift);

endmodule

// File: rtl/audio_clip_player.sv
// Streams one mono clip from an external synchronous ROM into the controller FIFO, holding each
// ROM sample for RATE_DIV writes and duplicating it onto both channels.
module audio_clip_player
  import audio_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int CLIP_LEN = 24000,
  parameter int ROM_W    = 16,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int RATE_DIV = 6
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    play_start,
  input  logic                    play_abort,
  input  logic [2:0]              volume,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic signed [ROM_W-1:0] rom_data,
  audio_clip_player_if.master     aud,
  output logic                    busy,
  output logic                    done
);

  localparam int REP_W = $clog2(RATE_DIV + 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(RATE_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CLIP_LEN - 1);

  state_t                     state, state_nxt;
  logic [REP_W-1:0]           rep_cnt;
  logic [2:0]                 vol_q;
  logic signed [SAMPLE_W-1:0] scaled_p0;
  logic signed [SAMPLE_W-1:0] sample_p1;

  logic wr_fire, last_rep, last_addr, abort_go, restart;

  // Abort only matters once playing, and it overrides a simultaneous start.
  assign abort_go  = play_abort && (state != IDLE);
  assign restart   = play_start && !abort_go;
  assign wr_fire   = (state == PUSH) && aud.audio_out_allowed;
  assign last_rep  = (rep_cnt >= REP_LAST);
  assign last_addr = (rom_addr >= ADDR_LAST);

  audio_volume_scale #(
    .ROM_W   (ROM_W),
    .SAMPLE_W(SAMPLE_W)
  ) u_scale (
    .sample(rom_data),
    .shift (vol_q),
    .scaled(scaled_p0)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_go) begin
      state_nxt = IDLE;
    end else if (restart) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: state_nxt = LOAD;
        LOAD:  state_nxt = PUSH;
        PUSH: begin
          if (aud.audio_out_allowed) begin
            if (!last_rep)       state_nxt = PUSH;
            else if (!last_addr) state_nxt = FETCH;
            else                 state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy                = (state != IDLE);
    aud.write_audio_out = wr_fire;
  end

  // p0 -> p1: the ROM word is scaled combinationally and registered in LOAD, so the sample
  // is stable for every strobe of the following PUSH run.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rom_addr  <= '0;
      rep_cnt   <= '0;
      vol_q     <= '0;
      sample_p1 <= '0;
      done      <= 1'b0;
    end else begin
      done <= wr_fire && last_rep && last_addr && !play_abort && !play_start;
      if (restart) begin
        rom_addr <= '0;
        rep_cnt  <= '0;
        vol_q    <= volume;
      end else if (!abort_go && wr_fire) begin
        if (!last_rep) begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end else if (!last_addr) begin
          rep_cnt  <= '0;
          rom_addr <= rom_addr + ADDR_W'(1);
        end
      end
      if (state == LOAD) sample_p1 <= scaled_p0;
    end
  end

  assign aud.left_channel_audio_out  = sample_p1;
  assign aud.right_channel_audio_out = sample_p1;

endmodule

// File: tb/tb_audio_clip_player.sv
// Randomised bench for audio_clip_player against a clip-level expected-write model.
module tb_audio_clip_player;
  localparam int ADDR_W   = 3;
  localparam int CLIP_LEN = 4;
  localparam int ROM_W    = 16;
  localparam int SAMPLE_W = 32;
  localparam int RATE_DIV = 2;
  localparam int NWR      = CLIP_LEN * RATE_DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              play_start = 1'b0;
  logic              play_abort = 1'b0;
  logic [2:0]        volume = 3'd0;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data = '0;
  logic              busy, done;

  audio_clip_player_if #(.SAMPLE_W(SAMPLE_W)) aud();

  audio_clip_player #(
    .ADDR_W(ADDR_W), .CLIP_LEN(CLIP_LEN), .ROM_W(ROM_W),
    .SAMPLE_W(SAMPLE_W), .RATE_DIV(RATE_DIV)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .play_start(play_start),
    .play_abort(play_abort),
    .volume    (volume),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .aud       (aud),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [ROM_W-1:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int allow_mode = 0;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    case (allow_mode)
      0:       aud.audio_out_allowed = 1'b1;
      1:       aud.audio_out_allowed = ((cyc % 3) == 0);
      default: aud.audio_out_allowed = 1'($urandom_range(0, 1));
    endcase
  end

  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  int done_cnt = 0, strobe_err = 0, lr_err = 0, last_wr_cyc = 0, done_cyc = 0;
  int n_checks = 0, n_fail = 0;

  always @(negedge clk) begin
    cyc++;
    if (aud.write_audio_out) begin
      wr_q.push_back(aud.left_channel_audio_out);
      if (aud.left_channel_audio_out !== aud.right_channel_audio_out) lr_err++;
      if (aud.audio_out_allowed !== 1'b1) strobe_err++;
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] ref_scale(input logic [15:0] w, input int v);
    longint s;
    s = longint'($signed(w)) * 65536;
    s = s >>> v;
    return s[31:0];
  endfunction

  task automatic build_model(input int v);
    exp_q.delete();
    for (int a = 0; a < CLIP_LEN; a++)
      for (int r = 0; r < RATE_DIV; r++)
        exp_q.push_back(ref_scale(rom[a], v));
  endtask

  task automatic clear_obs();
    wr_q.delete();
    done_cnt = 0; strobe_err = 0; lr_err = 0;
  endtask

  task automatic pulse_start(input logic [2:0] v);
    @(posedge clk); #1;
    volume = v; play_start = 1'b1;
    @(posedge clk); #1;
    play_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 6;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    if (aud.write_audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", aud.write_audio_out); end
    if (aud.left_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL reset_left: got %h want 0", aud.left_channel_audio_out); end
    if (aud.right_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL reset_right: got %h want 0", aud.right_channel_audio_out); end
    if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_clip(input string tag, input int mode, input int v);
    bit ok;
    allow_mode = mode;
    build_model(v);
    clear_obs();
    pulse_start(3'(v));
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: got no done want done", tag); end
    n_checks++;
    if (wr_q.size() != NWR) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", tag, wr_q.size(), NWR); end
    for (int i = 0; i < NWR && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, wr_q[i], exp_q[i]); end
    end
    n_checks += 5;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want 1", tag, done_cnt); end
    if (done_cyc != last_wr_cyc + 1) begin n_fail++; $display("FAIL %s_done_lat: got %0d want %0d", tag, done_cyc, last_wr_cyc + 1); end
    if (strobe_err != 0) begin n_fail++; $display("FAIL %s_strobe_blocked: got %0d want 0", tag, strobe_err); end
    if (lr_err != 0) begin n_fail++; $display("FAIL %s_left_right: got %0d want 0", tag, lr_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b want 0", tag, busy); end
  endtask

  task automatic test_basic();
    for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'((a + 1) << 8);
    run_clip("basic", 0, 0);
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'((a + 1) << 8);
    run_clip("duty3", 1, 0);
    run_clip("duty3_vol", 1, int'($urandom_range(0, 7)));
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'($urandom);
      run_clip("random", 2, int'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_volume_latch();
    bit ok;
    for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'h8000;
    allow_mode = 0;
    clear_obs();
    pulse_start(3'd3);
    wait_writes(3, 100, ok);
    @(posedge clk); #1;
    volume = 3'd0;
    wait_done(400, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL vol_timeout: got no done want done"); end
    if (wr_q.size() != NWR) begin n_fail++; $display("FAIL vol_count: got %0d want %0d", wr_q.size(), NWR); end
    for (int i = 0; i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== 32'hF000_0000) begin n_fail++; $display("FAIL vol_data[%0d]: got %h want f0000000", i, wr_q[i]); end
    end
  endtask

  task automatic test_restart();
    bit ok;
    int n_before;
    for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'($urandom);
    build_model(2);
    allow_mode = 0;
    clear_obs();
    pulse_start(3'd2);
    wait_writes(5, 100, ok);
    @(posedge clk); #1;
    play_start = 1'b1;
    @(negedge clk);
    n_before = wr_q.size();
    @(posedge clk); #1;
    play_start = 1'b0;
    n_checks += 3;
    if (rom_addr !== '0) begin n_fail++; $display("FAIL restart_addr: got %0d want 0", rom_addr); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", busy); end
    if (n_before < 5 || n_before >= NWR) begin n_fail++; $display("FAIL restart_prefix_len: got %0d want 5..%0d", n_before, NWR - 1); end
    wait_done(400, ok);
    n_checks += 3;
    if (!ok) begin n_fail++; $display("FAIL restart_timeout: got no done want done"); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); end
    if (wr_q.size() != n_before + NWR) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", wr_q.size(), n_before + NWR); end
    for (int i = 0; i < wr_q.size() && i < n_before + NWR; i++) begin
      n_checks++;
      if (wr_q[i] !== exp_q[(i < n_before) ? i : i - n_before]) begin
        n_fail++;
        $display("FAIL restart_data[%0d]: got %h want %h", i, wr_q[i], exp_q[(i < n_before) ? i : i - n_before]);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int n_at;
    for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'($urandom);
    build_model(1);
    allow_mode = 0;
    clear_obs();
    pulse_start(3'd1);
    wait_writes(3, 100, ok);
    @(posedge clk); #1;
    play_start = 1'b1; play_abort = 1'b1;
    @(negedge clk);
    n_at = wr_q.size();
    @(posedge clk); #1;
    play_start = 1'b0; play_abort = 1'b0;
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (aud.write_audio_out !== 1'b0) begin n_fail++; $display("FAIL abort_write: got %b want 0", aud.write_audio_out); end
    repeat (20) @(negedge clk);
    n_checks += 3;
    if (wr_q.size() != n_at) begin n_fail++; $display("FAIL abort_extra_writes: got %0d want %0d", wr_q.size(), n_at); end
    if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", busy); end
    for (int i = 0; i < n_at && i < NWR; i++) begin
      n_checks++;
      if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_data[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_at;
    for (int a = 0; a < CLIP_LEN; a++) rom[a] = 16'($urandom);
    allow_mode = 0;
    clear_obs();
    pulse_start(3'd4);
    wait_writes(3, 100, ok);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_at = wr_q.size();
    @(posedge clk); #1;
    n_checks += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (aud.write_audio_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_write: got %b want 0", aud.write_audio_out); end
    if (aud.left_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_left: got %h want 0", aud.left_channel_audio_out); end
    if (rom_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr: got %0d want 0", rom_addr); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_checks += 2;
    if (wr_q.size() != n_at) begin n_fail++; $display("FAIL rstmid_extra_writes: got %0d want %0d", wr_q.size(), n_at); end
    if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done_cnt: got %0d want 0", done_cnt); end
    run_clip("after_reset", 0, int'($urandom_range(0, 7)));
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) rom[a] = '0;
    aud.audio_out_allowed = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_volume_latch();
    test_restart();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
